// File: rtl/adc_spi_master.sv
// Three-wire SPI master for the ADC configuration path (mode 0, SDIO turnaround on reads).
// Define ADC_SPI_LOOPBACK_EN to loop the driven SDIO bit back into the capture path.
module adc_spi_master #(
  parameter int MOSI_DATA_WIDTH = 24,
  parameter int MISO_DATA_WIDTH = 8,
  parameter int CLK_DIV         = 4,
  parameter int CS_SETUP        = 2,
  parameter int CS_HOLD         = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_spi_wr_cmd,
  input  logic                       i_spi_rd_cmd,
  input  logic [MOSI_DATA_WIDTH-1:0] i_spi_wr_data,
  output logic [MISO_DATA_WIDTH-1:0] o_spi_rd_data,
  output logic                       o_spi_busy,
  output logic                       o_spi_done,
  output logic                       o_spi_sclk,
  output logic                       o_spi_csb,
  output logic                       o_spi_sdio_o,
  output logic                       o_spi_sdio_t,
  input  logic                       i_spi_sdio_i
);

  localparam int W    = MOSI_DATA_WIDTH;
  localparam int M    = MISO_DATA_WIDTH;
  localparam int C1   = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
  localparam int CMAX = (C1 > CS_HOLD) ? C1 : CS_HOLD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BW   = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [BW-1:0]  bit_cnt, bit_cnt_nx;
  logic [W-1:0]   shreg, shreg_nx;
  logic [M-1:0]   cap, cap_nx;
  logic [M-1:0]   rd_data, rd_data_nx;
  logic           is_rd, is_rd_nx;
  logic           sclk, sclk_nx;
  logic           csb, csb_nx;
  logic           sdio_o, sdio_o_nx;
  logic           sdio_t, sdio_t_nx;
  logic           busy, busy_nx;
  logic           done, done_nx;
  logic           sample;

`ifdef ADC_SPI_LOOPBACK_EN
  assign sample = sdio_o & (i_spi_sdio_i | 1'b1);
`else
  assign sample = i_spi_sdio_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      cap     <= '0;
      rd_data <= '0;
      is_rd   <= 1'b0;
      sclk    <= 1'b0;
      csb     <= 1'b1;
      sdio_o  <= 1'b0;
      sdio_t  <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      cap     <= cap_nx;
      rd_data <= rd_data_nx;
      is_rd   <= is_rd_nx;
      sclk    <= sclk_nx;
      csb     <= csb_nx;
      sdio_o  <= sdio_o_nx;
      sdio_t  <= sdio_t_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    cap_nx     = cap;
    rd_data_nx = rd_data;
    is_rd_nx   = is_rd;
    sclk_nx    = sclk;
    csb_nx     = csb;
    sdio_o_nx  = sdio_o;
    sdio_t_nx  = sdio_t;
    busy_nx    = busy;
    done_nx    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_spi_wr_cmd | i_spi_rd_cmd) begin
          state_nx  = S_CS_SETUP;
          cnt_nx    = '0;
          is_rd_nx  = i_spi_rd_cmd;
          // Direction bit is owned by the command, not the data word
          shreg_nx  = {i_spi_rd_cmd, i_spi_wr_data[W-2:0]};
          cap_nx    = '0;
          busy_nx   = 1'b1;
          csb_nx    = 1'b0;
          sdio_o_nx = i_spi_rd_cmd;
          sdio_t_nx = 1'b0;
        end
      end
      S_CS_SETUP: begin
        if (cnt == CW'(CS_SETUP - 1)) begin
          state_nx   = S_SHIFT;
          cnt_nx     = '0;
          bit_cnt_nx = BW'(W - 1);
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_SHIFT: begin
        if (cnt != CW'(CLK_DIV - 1)) begin
          cnt_nx = cnt + CW'(1);
        end else begin
          cnt_nx = '0;
          if (!sclk) begin
            sclk_nx = 1'b1;
            cap_nx  = {cap[M-2:0], sample};
          end else begin
            sclk_nx = 1'b0;
            if (bit_cnt == '0) begin
              state_nx  = S_CS_HOLD;
              sdio_o_nx = 1'b0;
            end else begin
              bit_cnt_nx = bit_cnt - BW'(1);
              shreg_nx   = {shreg[W-2:0], 1'b0};
              sdio_o_nx  = shreg[W-2];
              // Release the pad as the read data phase begins
              if (is_rd && bit_cnt == BW'(M))
                sdio_t_nx = 1'b1;
`ifndef ADC_SPI_LOOPBACK_EN
              if (is_rd && bit_cnt <= BW'(M))
                sdio_o_nx = 1'b0;
`endif
            end
          end
        end
      end
      S_CS_HOLD: begin
        if (cnt == CW'(CS_HOLD - 1)) begin
          state_nx  = S_DONE;
          cnt_nx    = '0;
          csb_nx    = 1'b1;
          done_nx   = 1'b1;
          sdio_t_nx = 1'b1;
          if (is_rd)
            rd_data_nx = cap;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign o_spi_rd_data = rd_data;
  assign o_spi_busy    = busy;
  assign o_spi_done    = done;
  assign o_spi_sclk    = sclk;
  assign o_spi_csb     = csb;
  assign o_spi_sdio_o  = sdio_o;
  assign o_spi_sdio_t  = sdio_t;

endmodule
